// File: rtl/case_sel_pkg.sv
// Shared types for the case-select datapath:
// select classes, key constants and the operand bundle.
package case_sel_pkg;

  localparam int OP_N     = 32;
  localparam int OP_SEQ_W = 8;

  localparam int SEL_K42 = 42;
  localparam int SEL_K69 = 69;

  typedef enum logic [1:0] {
    CLS_LOW  = 2'd0,
    CLS_42   = 2'd1,
    CLS_69   = 2'd2,
    CLS_NONE = 2'd3
  } cls_t;

  typedef struct packed {
    logic [OP_N-1:0]     valA;
    logic [OP_N-1:0]     valB;
    logic [OP_N-1:0]     valC;
    cls_t                cls;
    logic [OP_SEQ_W-1:0] seq;
  } operand_t;

endpackage

// File: rtl/case_sel_classify.sv
// Combinational valA classifier; the downstream
// select stage reuses it for its own checks.
module case_sel_classify
  import case_sel_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0] val,
  output cls_t         cls
);

  always_comb begin
    cls = CLS_NONE;
    unique case (1'b1)
      (val[N-1:1] == '0):     cls = CLS_LOW;
      (val == N'(SEL_K42)):   cls = CLS_42;
      (val == N'(SEL_K69)):   cls = CLS_69;
      default:                cls = CLS_NONE;
    endcase
  end

endmodule

// File: rtl/case_operand_skid.sv
// Operand stage: 2-entry skid buffer with registered
// ready, pre-classified selector and sequence tag.
module case_operand_skid
  import case_sel_pkg::*;
#(
  parameter int N     = 32,
  parameter int SEQ_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             IN_inValid,
  output logic             OUT_inReady,
  input  logic [N-1:0]     IN_valA,
  input  logic [N-1:0]     IN_valB,
  input  logic [N-1:0]     IN_valC,
  output logic             OUT_outValid,
  input  logic             IN_outReady,
  output logic [N-1:0]     OUT_valA,
  output logic [N-1:0]     OUT_valB,
  output logic [N-1:0]     OUT_valC,
  output logic [1:0]       OUT_cls,
  output logic [SEQ_W-1:0] OUT_seq
);

  typedef struct packed {
    logic [N-1:0]     valA;
    logic [N-1:0]     valB;
    logic [N-1:0]     valC;
    cls_t             cls;
    logic [SEQ_W-1:0] seq;
  } op_t;

  op_t              main_q, main_d;
  op_t              skid_q, skid_d;
  op_t              in_op;
  logic             mainv_q, mainv_d;
  logic             skidv_q, skidv_d;
  logic             rdy_q;
  logic [SEQ_W-1:0] seq_q;
  cls_t             in_cls;
  logic             acc, cons;

  case_sel_classify #(.N(N)) u_cls (
    .val (IN_valA),
    .cls (in_cls)
  );

  assign acc  = IN_inValid && rdy_q;
  assign cons = mainv_q && IN_outReady;

  always_comb begin
    in_op.valA = IN_valA;
    in_op.valB = IN_valB;
    in_op.valC = IN_valC;
    in_op.cls  = in_cls;
    in_op.seq  = seq_q;
  end

  // rdy_q mirrors !skidv_q, so acc never lands on a full skid
  always_comb begin
    main_d  = main_q;
    mainv_d = mainv_q;
    skid_d  = skid_q;
    skidv_d = skidv_q;
    if (cons) begin
      if (skidv_q) begin
        main_d  = skid_q;
        skidv_d = 1'b0;
      end else if (acc) begin
        main_d = in_op;
      end else begin
        mainv_d = 1'b0;
      end
    end else if (acc) begin
      if (mainv_q) begin
        skid_d  = in_op;
        skidv_d = 1'b1;
      end else begin
        main_d  = in_op;
        mainv_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_q  <= '0;
      skid_q  <= '0;
      mainv_q <= 1'b0;
      skidv_q <= 1'b0;
      rdy_q   <= 1'b1;
      seq_q   <= '0;
    end else begin
      main_q  <= main_d;
      skid_q  <= skid_d;
      mainv_q <= mainv_d;
      skidv_q <= skidv_d;
      rdy_q   <= !skidv_d;
      if (acc)
        seq_q <= seq_q + 1'b1;
    end
  end

  assign OUT_inReady  = rdy_q;
  assign OUT_outValid = mainv_q;
  assign OUT_valA     = main_q.valA;
  assign OUT_valB     = main_q.valB;
  assign OUT_valC     = main_q.valC;
  assign OUT_cls      = main_q.cls;
  assign OUT_seq      = main_q.seq;

endmodule

// File: tb/tb_case_operand_skid.sv
// Randomized bench for case_operand_skid against a
// queue-based reference of the accepted triplet stream.
module tb_case_operand_skid;

  localparam int N     = 32;
  localparam int SEQ_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     va, vb, vc;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     oa, ob, oc;
  logic [1:0]       ocls;
  logic [SEQ_W-1:0] oseq;

  case_operand_skid #(.N(N), .SEQ_W(SEQ_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .IN_inValid   (in_valid),
    .OUT_inReady  (in_ready),
    .IN_valA      (va),
    .IN_valB      (vb),
    .IN_valC      (vc),
    .OUT_outValid (out_valid),
    .IN_outReady  (out_ready),
    .OUT_valA     (oa),
    .OUT_valB     (ob),
    .OUT_valC     (oc),
    .OUT_cls      (ocls),
    .OUT_seq      (oseq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] a, b, c;
    int           cls;
    int           seq;
  } exp_t;

  exp_t q[$];
  int   seq_m;
  int   total = 0;
  int   bad   = 0;
  int   n_out;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_cls(input logic [N-1:0] a);
    if (a < 2)            return 0;
    else if (a == 42)     return 1;
    else if (a == 69)     return 2;
    else                  return 3;
  endfunction

  task automatic drive(input logic v, input logic [N-1:0] a,
                       input logic [N-1:0] b, input logic [N-1:0] c,
                       input logic ordy);
    in_valid  = v;
    va        = a;
    vb        = b;
    vc        = c;
    out_ready = ordy;
  endtask

  // one cycle: check at negedge, advance model, cross posedge
  task automatic step();
    bit acc, cons;
    exp_t e;
    @(negedge clk);
    if (rst) begin
      q.delete();
      seq_m = 0;
    end else begin
      chk("valid", 64'(out_valid), 64'(q.size() > 0));
      chk("ready", 64'(in_ready), 64'(q.size() < 2));
      if (q.size() > 0) begin
        chk("valA", 64'(oa), 64'(q[0].a));
        chk("valB", 64'(ob), 64'(q[0].b));
        chk("valC", 64'(oc), 64'(q[0].c));
        chk("cls", 64'(ocls), 64'(q[0].cls));
        chk("seq", 64'(oseq), 64'(q[0].seq));
      end
      acc  = in_valid && (q.size() < 2);
      cons = out_ready && (q.size() > 0);
      if (cons) begin
        void'(q.pop_front());
        n_out++;
      end
      if (acc) begin
        e.a   = va;
        e.b   = vb;
        e.c   = vc;
        e.cls = ref_cls(va);
        e.seq = seq_m;
        q.push_back(e);
        seq_m = (seq_m + 1) % (1 << SEQ_W);
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N-1:0] pick_a();
    case ($urandom_range(0, 5))
      0:       return 0;
      1:       return 1;
      2:       return 42;
      3:       return 69;
      default: return $urandom();
    endcase
  endfunction

  int cls_exp[6] = '{0, 0, 3, 1, 2, 3};
  logic [N-1:0] sweep[6] = '{0, 1, 2, 42, 69, 32'hFFFF_FFFF};

  initial begin
    n_out = 0;
    seq_m = 0;
    rst   = 1'b1;
    drive(1'b1, 7, 7, 7, 1'b1);
    step();
    step();
    rst = 1'b0;
    drive(1'b0, 0, 0, 0, 1'b1);
    step();
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk("rst_valA", 64'(oa), 64'd0);

    // single triplet, 1-cycle latency
    drive(1'b1, 42, 5, 9, 1'b1);
    step();
    drive(1'b0, 0, 0, 0, 1'b1);
    chk("t1_valid", 64'(out_valid), 64'd1);
    chk("t1_cls", 64'(ocls), 64'd1);
    chk("t1_seq", 64'(oseq), 64'd0);
    chk("t1_valC", 64'(oc), 64'd9);
    chk("t1_ready", 64'(in_ready), 64'd1);
    step();

    // classification sweep
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, sweep[i], i, i, 1'b1);
      step();
      chk("sweep_cls", 64'(ocls), 64'(cls_exp[i]));
      chk("sweep_seq", 64'(oseq), 64'(i + 1));
    end
    drive(1'b0, 0, 0, 0, 1'b1);
    step();

    // backpressure into the skid
    drive(1'b1, 69, 1, 2, 1'b0);
    step();
    drive(1'b1, 7, 3, 4, 1'b0);
    step();
    drive(1'b0, 0, 0, 0, 1'b0);
    chk("bp_ready", 64'(in_ready), 64'd0);
    chk("bp_holdA", 64'(oa), 64'd69);
    chk("bp_holdcls", 64'(ocls), 64'd2);
    step();
    step();
    out_ready = 1'b1;
    step();
    chk("bp_second", 64'(oa), 64'd7);
    chk("bp_ready_back", 64'(in_ready), 64'd1);
    step();
    drive(1'b0, 0, 0, 0, 1'b1);
    step();

    // streaming with seq wrap
    n_out = 0;
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, pick_a(), $urandom(), $urandom(), 1'b1);
      step();
    end
    drive(1'b0, 0, 0, 0, 1'b1);
    step();
    chk("stream_count", 64'(n_out), 64'd300);

    // reset with both entries full
    drive(1'b1, 69, 1, 1, 1'b0);
    step();
    drive(1'b1, 70, 2, 2, 1'b0);
    step();
    drive(1'b0, 0, 0, 0, 1'b0);
    chk("mid_full", 64'(in_ready), 64'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    chk("mid_valid", 64'(out_valid), 64'd0);
    chk("mid_ready", 64'(in_ready), 64'd1);
    drive(1'b1, 3, 4, 5, 1'b1);
    step();
    drive(1'b0, 0, 0, 0, 1'b1);
    chk("mid_seq0", 64'(oseq), 64'd0);
    step();

    // random valid/ready stress
    for (int i = 0; i < 10000; i++) begin
      drive($urandom_range(0, 3) != 0, pick_a(), $urandom(),
            $urandom(), $urandom_range(0, 2) != 0);
      step();
    end
    drive(1'b0, 0, 0, 0, 1'b1);
    for (int i = 0; i < 4; i++)
      step();
    chk("drain_empty", 64'(q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
